// File: rtl/text_writer.sv
// text_writer: turns a console byte stream into writes on the 80x30 text
// buffer port, tracking the cursor and expanding line/screen clears into
// one blank write per cycle.
module text_writer #(
  parameter int         CHAR_W         = 8,
  parameter logic [7:0] BLANK          = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CHAR_W-1:0] new_char,
  output logic [11:0]       waddr,
  output logic              we,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLR_LINE = 2'd1;
  localparam logic [1:0] CLR_ALL  = 2'd2;
  localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? CLR_ALL : IDLE;

  localparam logic [6:0] LAST_COL = 7'd79;
  localparam logic [4:0] LAST_ROW = 5'd29;

  logic [1:0]        state, state_nx;
  logic [4:0]        row_nx;
  logic [6:0]        col_nx;
  logic [4:0]        clr_row, clr_row_nx;
  logic [6:0]        clr_col, clr_col_nx;
  logic              wr_en_p0;
  logic [11:0]       wr_addr_p0;
  logic [CHAR_W-1:0] wr_data_p0;
  logic              accept;
  logic [4:0]        row_inc;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // Row below the cursor, wrapping the bottom row back to the top.
  assign row_inc  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

  // Next-state, cursor and write-request decode for the current cycle.
  always_comb begin
    state_nx   = state;
    row_nx     = cursor_row;
    col_nx     = cursor_col;
    clr_row_nx = clr_row;
    clr_col_nx = clr_col;
    wr_en_p0   = 1'b0;
    wr_addr_p0 = 12'd0;
    wr_data_p0 = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wr_en_p0   = 1'b1;
            wr_addr_p0 = {cursor_row, cursor_col};
            wr_data_p0 = in_char[CHAR_W-1:0];
            if (cursor_col == LAST_COL) begin
              // Wrapping onto a new line blanks it, like a LF would.
              col_nx     = 7'd0;
              row_nx     = row_inc;
              clr_col_nx = 7'd0;
              state_nx   = CLR_LINE;
            end else begin
              col_nx = cursor_col + 7'd1;
            end
          end else begin
            case (in_char)
              8'h0A: begin
                col_nx     = 7'd0;
                row_nx     = row_inc;
                clr_col_nx = 7'd0;
                state_nx   = CLR_LINE;
              end
              8'h0D: col_nx = 7'd0;
              8'h08: begin
                if (cursor_col != 7'd0) begin
                  col_nx     = cursor_col - 7'd1;
                  wr_en_p0   = 1'b1;
                  wr_addr_p0 = {cursor_row, cursor_col - 7'd1};
                  wr_data_p0 = BLANK[CHAR_W-1:0];
                end
              end
              8'h0C: begin
                row_nx     = 5'd0;
                col_nx     = 7'd0;
                clr_row_nx = 5'd0;
                clr_col_nx = 7'd0;
                state_nx   = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        // The cursor row is stable here: no byte is accepted mid-clear.
        wr_en_p0   = 1'b1;
        wr_addr_p0 = {cursor_row, clr_col};
        wr_data_p0 = BLANK[CHAR_W-1:0];
        if (clr_col == LAST_COL) begin
          state_nx = IDLE;
        end else begin
          clr_col_nx = clr_col + 7'd1;
        end
      end
      CLR_ALL: begin
        wr_en_p0   = 1'b1;
        wr_addr_p0 = {clr_row, clr_col};
        wr_data_p0 = BLANK[CHAR_W-1:0];
        if (clr_col == LAST_COL) begin
          clr_col_nx = 7'd0;
          if (clr_row == LAST_ROW) begin
            state_nx = IDLE;
          end else begin
            clr_row_nx = clr_row + 5'd1;
          end
        end else begin
          clr_col_nx = clr_col + 7'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, cursor and clear counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      cursor_row <= 5'd0;
      cursor_col <= 7'd0;
      clr_row    <= 5'd0;
      clr_col    <= 7'd0;
    end else begin
      state      <= state_nx;
      cursor_row <= row_nx;
      cursor_col <= col_nx;
      clr_row    <= clr_row_nx;
      clr_col    <= clr_col_nx;
    end
  end

  // Buffer write port registered one cycle behind the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we       <= 1'b0;
      waddr    <= 12'd0;
      new_char <= '0;
    end else begin
      we       <= wr_en_p0;
      waddr    <= wr_addr_p0;
      new_char <= wr_data_p0;
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Testbench for text_writer: directed byte sequences with a write scoreboard.
module tb_text_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  new_char;
  logic [11:0] waddr;
  logic        we;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;
  logic [19:0] exp_q[$];
  int m_row = 0;
  int m_col = 0;

  text_writer dut (
    .clk(clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .new_char(new_char), .waddr(waddr), .we(we),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every buffer write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%02h, none expected", waddr, new_char);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {20'd0, waddr}, {20'd0, e[19:8]});
        chk("write_data", {24'd0, new_char}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic push_wr(input int r, input int c, input logic [7:0] d);
    logic [11:0] a;
    a = {5'(r), 7'(c)};
    exp_q.push_back({a, d});
  endtask

  task automatic push_line(input int r);
    for (int c = 0; c < 80; c++) push_wr(r, c, 8'h20);
  endtask

  task automatic push_all();
    for (int r = 0; r < 30; r++) push_line(r);
  endtask

  // Present a byte at a negedge and hold it until accepted; returns at the
  // negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int waited);
    in_char  = b;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte 0x%02h not accepted after %0d cycles", b, waited);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Update the reference cursor, queue the expected writes, then send.
  task automatic tx(input logic [7:0] b, output int waited);
    int nr;
    nr = (m_row == 29) ? 0 : m_row + 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row, m_col, b);
      if (m_col == 79) begin
        m_col = 0;
        m_row = nr;
        push_line(m_row);
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = nr;
      push_line(m_row);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      push_all();
    end
    send(b, waited);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready still low after %0d cycles", n);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic lf_and_wait();
    int w, n;
    tx(8'h0A, w);
    wait_ready(n);
  endtask

  initial begin
    int w, n, base;
    rst_n    = 1'b0;
    in_char  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_new_char", new_char, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_ready", in_ready, 0);

    // Power-up clear of the whole screen.
    push_all();
    rst_n = 1'b1;
    wait_ready(n);
    chk("por_clear_cycles", n, 2400);
    drain("por_clear_writes_left");
    chk("por_row", cursor_row, 0);
    chk("por_col", cursor_col, 0);

    // "AB" back to back.
    tx(8'h41, w);
    chk("A_wait", w, 0);
    tx(8'h42, w);
    chk("B_wait", w, 0);
    chk("AB_ready", in_ready, 1);
    drain("AB_writes_left");
    chk("AB_row", cursor_row, 0);
    chk("AB_col", cursor_col, 2);

    // Move to (3,79) and send 'Z'.
    tx(8'h0D, w);
    repeat (3) lf_and_wait();
    for (int i = 0; i < 79; i++) tx(8'h2E, w);
    chk("pre_Z_col", cursor_col, 79);
    chk("pre_Z_row", cursor_row, 3);
    drain("pre_Z_writes_left");
    exp_q.push_back({12'h1CF, 8'h5A});
    push_line(4);
    m_row = 4;
    m_col = 0;
    send(8'h5A, w);
    wait_ready(n);
    chk("Z_ready_low_cycles", n, 80);
    drain("Z_writes_left");
    chk("Z_row", cursor_row, 4);
    chk("Z_col", cursor_col, 0);

    // Move to (29,10) and send LF: wraps to row 0.
    repeat (25) lf_and_wait();
    for (int i = 0; i < 10; i++) tx(8'h30 + 8'(i), w);
    chk("pre_LF_row", cursor_row, 29);
    tx(8'h0A, w);
    wait_ready(n);
    chk("LF_ready_low_cycles", n, 80);
    drain("LF_writes_left");
    chk("LF_row", cursor_row, 0);
    chk("LF_col", cursor_col, 0);

    // Backspace at column 0 and at column 7.
    repeat (5) lf_and_wait();
    drain("pre_BS_writes_left");
    base = wr_seen;
    send(8'h08, w);
    drain("BS0_writes_left");
    chk("BS0_no_write", wr_seen - base, 0);
    chk("BS0_row", cursor_row, 5);
    chk("BS0_col", cursor_col, 0);
    for (int i = 0; i < 7; i++) tx(8'h61, w);
    drain("pre_BS7_writes_left");
    exp_q.push_back({12'h286, 8'h20});
    m_col = 6;
    send(8'h08, w);
    drain("BS7_writes_left");
    chk("BS7_row", cursor_row, 5);
    chk("BS7_col", cursor_col, 6);

    // Form feed with 'Q' held during the clear; also a stray byte ignored.
    tx(8'h07, w);
    chk("bell_col", cursor_col, 6);
    tx(8'h0C, w);
    chk("FF_row", cursor_row, 0);
    chk("FF_col", cursor_col, 0);
    push_wr(0, 0, 8'h51);
    m_col = 1;
    send(8'h51, w);
    chk("Q_held_cycles", w, 2400);
    drain("FF_Q_writes_left");
    chk("Q_row", cursor_row, 0);
    chk("Q_col", cursor_col, 1);

    // Reset in the middle of a screen clear.
    tx(8'h0C, w);
    base = wr_seen;
    n = 0;
    while (wr_seen - base < 1000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_point_reached", (wr_seen - base >= 1000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", we, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_col", cursor_col, 0);
    exp_q.delete();
    push_all();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("restart_clear_cycles", n, 2400);
    drain("restart_writes_left");
    chk("restart_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
